fpu_req_arbiter: RTL and testbench
==================================

Name: fpu_req_arbiter

Overview:
- Shares one fixed-point unit (Q15, 64-bit signed) between NREQ requesters.
- Each requester issues one operation through a valid/ready handshake. Grants rotate round-robin.
- The block drives the FPU operand/opcode inputs from internal registers and sequences the multi-cycle divide using the FPU busy flag.
- The single result is returned through a registered valid/ready response port, tagged with the requester index.
- Sits between the ray/shading sequencers and the FPU instance.

Parameters:
NREQ, 2, number of requesters (2..8)
TAG_W, $clog2(NREQ) (min 1), width of resp_id
DIV_MAX_CYCLES, 128, divide watchdog limit in cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  request present, one bit per requester
req_ready  out  NREQ  one-hot grant pulse; request is consumed this cycle
req_op  in  4*NREQ  flattened FPU opcodes, requester i at [4i+3:4i]
req_a  in  64*NREQ  flattened operand A
req_b  in  64*NREQ  flattened operand B
resp_valid  out  1  response held
resp_ready  in  1  response consumed
resp_data  out  64  result
resp_id  out  TAG_W  index of the granted requester
resp_err  out  1  illegal opcode or divide timeout
fpu_op  out  4  to FPU opcode input
fpu_a  out  64  to FPU operand A
fpu_b  out  64  to FPU operand B
fpu_busy  in  1  FPU divider busy
fpu_res  in  64  FPU result

Behaviour:
- Reset values:
  - state=IDLE; rr pointer=0; req_ready=0.
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - op register=4'b0000; operand registers=0.
- fpu_op/fpu_a/fpu_b are always driven from the registers, never from req_* directly.
- The op register holds 4'b0000 whenever state is IDLE. This prevents spurious divider launches.
- Legal opcodes: 0000-0110, 1000-1010, 1100, 1101. All others are illegal.
- States and transitions:
  - IDLE:
    - Grant only when some req_valid is set and the response slot is free: !resp_valid || resp_ready in the same cycle.
    - Winner = first set req_valid scanning from the pointer upward, modulo NREQ.
    - Pulse req_ready[winner] for exactly one cycle.
    - Load the op/operand/id registers.
    - pointer <= winner+1 (mod NREQ).
    - Next state = EXEC.
  - EXEC, illegal op: capture resp_data=0, resp_err=1; go to IDLE.
  - EXEC, op != 0011: capture fpu_res into resp_data, resp_err=0; go to IDLE. This is one EXEC cycle, so grant-to-resp_valid latency is 2 cycles.
  - EXEC, op == 0011:
    - If fpu_busy==0, the FPU launches this cycle; go to DIV_WAIT, clear seen_busy and the watchdog.
    - If fpu_busy==1 (residual divide still running), stay in EXEC.
  - DIV_WAIT:
    - Set seen_busy when fpu_busy==1.
    - On the first cycle with seen_busy set and fpu_busy==0, capture fpu_res and go to IDLE.
    - A relaunch triggered in that capture cycle is tolerated; a later divide waits in EXEC.
  - Watchdog: counts DIV_WAIT cycles. At DIV_MAX_CYCLES, capture resp_data=0, resp_err=1, and go to IDLE.
- Response slot:
  - resp_valid is set on capture and cleared on the resp_valid && resp_ready edge.
  - Capture never collides with a held response, because grants require a free slot.
- Same-cycle resp_ready and grant: allowed (back-to-back throughput).
- Requesters hold their payload until req_ready. A requester dropping req_valid without a grant is legal and loses nothing.
- Asynchronous reset mid-divide returns all state to reset values immediately. The FPU's own reset clears its divider.
- The block has no arithmetic of its own. Results pass bit-exact.

Decomposition:
- Package fpu_ctrl_pkg holds:
  - FPU opcode localparams (FOP_ADD..FOP_MAX).
  - Function is_legal_fop(op).
  - State encoding IDLE/EXEC/DIV_WAIT.
- Sub-module rr_arbiter, parameterised by NREQ:
  - Inputs: request vector, advance enable.
  - Outputs: one-hot grant and encoded index.
  - Owns the rotating pointer.

Test Plan:
- Reset: assert reset mid-cycle with req_valid=2'b11 → all outputs 0 asynchronously; no req_ready while reset is high.
- Add: req0 op=0000, a=0x8000, b=0x10000 → req_ready[0] pulses; 2 cycles later resp_valid=1, resp_data=0x18000, resp_id=0, resp_err=0.
- Round-robin: both requesters continuously issue min (op=1100) with resp_ready=1 → grant order 0,1,0,1; resp_id alternates.
- Divide with backpressure: req1 op=0011, a=0x30000, b=0x10000; model FPU busy for 10 cycles → resp_data=0x18000 after busy falls; held stable while resp_ready=0 for 5 cycles; no new grant until the response is accepted.
- Illegal op 4'b0111 → resp_err=1, resp_data=0 after 2 cycles; the next request proceeds normally.
- Watchdog: FPU busy stuck high, DIV_MAX_CYCLES=16 → resp_err=1 after 16 DIV_WAIT cycles; state returns to IDLE and fpu_op=0000.

Source files
------------

// File: rtl/fpu_req_arbiter_pkg.sv
// Shared definitions for the FPU request arbiter.
// Holds the FPU opcode encodings, the legal-opcode check used to flag
// illegal requests, and the arbiter state encoding.
package fpu_ctrl_pkg;

  localparam logic [3:0] FOP_ADD   = 4'b0000;
  localparam logic [3:0] FOP_SUB   = 4'b0001;
  localparam logic [3:0] FOP_MUL   = 4'b0010;
  localparam logic [3:0] FOP_DIV   = 4'b0011;
  localparam logic [3:0] FOP_NEG   = 4'b0100;
  localparam logic [3:0] FOP_ABS   = 4'b0101;
  localparam logic [3:0] FOP_ASR   = 4'b0110;
  localparam logic [3:0] FOP_CMPLT = 4'b1000;
  localparam logic [3:0] FOP_CMPLE = 4'b1001;
  localparam logic [3:0] FOP_CMPEQ = 4'b1010;
  localparam logic [3:0] FOP_MIN   = 4'b1100;
  localparam logic [3:0] FOP_MAX   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_DIV_WAIT = 2'd2
  } fpu_state_e;

  // Opcodes 0111, 1011, 1110 and 1111 have no FPU operation behind them.
  function automatic logic is_legal_fop(input logic [3:0] op);
    logic legal;
    case (op)
      FOP_ADD, FOP_SUB, FOP_MUL, FOP_DIV, FOP_NEG, FOP_ABS, FOP_ASR,
      FOP_CMPLT, FOP_CMPLE, FOP_CMPEQ, FOP_MIN, FOP_MAX: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fpu_req_arbiter_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   req_i         - request vector, one bit per requester
//   advance_i     - the current winner is being served; move the pointer past it
//   grant_o       - one-hot winner (combinational)
//   idx_o         - encoded winner index
//   any_o         - at least one request is present
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic             advance_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [TAG_W-1:0] idx_o,
  output logic             any_o
);

  logic [TAG_W-1:0] ptr_q;
  int               cand;

  // Scan upward from the pointer, wrapping at NREQ; the first set bit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = TAG_W'(cand);
      end
    end
  end

  // The pointer moves to the slot just after the served requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && any_o) begin
      if (idx_o == TAG_W'(NREQ - 1)) ptr_q <= '0;
      else                           ptr_q <= idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one Q15 fixed-point unit between NREQ requesters.
// Ports:
//   clk_i, reset_i           - clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  - per-requester handshake; req_ready_o is a one-hot grant
//   req_op_i/req_a_i/req_b_i - flattened payloads, requester i at slice i
//   resp_*                   - registered response slot tagged with requester index
//   fpu_op_o/fpu_a_o/fpu_b_o - registered FPU inputs
//   fpu_busy_i/fpu_res_i     - FPU divider busy flag and result
module fpu_req_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TAG_W          = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int DIV_MAX_CYCLES = 128
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [4*NREQ-1:0]  req_op_i,
  input  logic [64*NREQ-1:0] req_a_i,
  input  logic [64*NREQ-1:0] req_b_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [63:0]        resp_data_o,
  output logic [TAG_W-1:0]   resp_id_o,
  output logic               resp_err_o,
  output logic [3:0]         fpu_op_o,
  output logic [63:0]        fpu_a_o,
  output logic [63:0]        fpu_b_o,
  input  logic               fpu_busy_i,
  input  logic [63:0]        fpu_res_i
);

  localparam int CNT_W = $clog2(DIV_MAX_CYCLES + 1);

  fpu_state_e       state_q;
  logic [3:0]       op_q;
  logic [63:0]      a_q, b_q;
  logic [TAG_W-1:0] id_q;
  logic             seen_busy_q;
  logic [CNT_W-1:0] wdog_q;
  logic             resp_valid_q, resp_err_q;
  logic [63:0]      resp_data_q;
  logic [TAG_W-1:0] resp_id_q;

  logic [NREQ-1:0]  grant;
  logic [TAG_W-1:0] win_idx;
  logic             any_req;
  logic             grant_fire;

  rr_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .req_i     (req_valid_i),
    .advance_i (grant_fire),
    .grant_o   (grant),
    .idx_o     (win_idx),
    .any_o     (any_req)
  );

  // A grant needs a free response slot; a slot being drained this same
  // cycle counts as free. Reset masks the grant so nothing is consumed
  // while the block is held in reset.
  assign grant_fire  = !reset_i && (state_q == ST_IDLE) && any_req &&
                       (!resp_valid_q || resp_ready_i);
  assign req_ready_o = grant_fire ? grant : '0;

  assign fpu_op_o     = op_q;
  assign fpu_a_o      = a_q;
  assign fpu_b_o      = b_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign resp_err_o   = resp_err_q;

  // Control FSM. The op register returns to 0000 on every exit to IDLE so
  // the FPU never sees a stale divide opcode while idle. A capture always
  // lands in a free slot, so it simply overrides the drain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'b0000;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      seen_busy_q  <= 1'b0;
      wdog_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      if (resp_valid_q && resp_ready_i) resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_fire) begin
            op_q    <= req_op_i[4*win_idx +: 4];
            a_q     <= req_a_i[64*win_idx +: 64];
            b_q     <= req_b_i[64*win_idx +: 64];
            id_q    <= win_idx;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!is_legal_fop(op_q)) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_id_q    <= id_q;
            op_q         <= 4'b0000;
            state_q      <= ST_IDLE;
          end else if (op_q != FOP_DIV) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fpu_res_i;
            resp_err_q   <= 1'b0;
            resp_id_q    <= id_q;
            op_q         <= 4'b0000;
            state_q      <= ST_IDLE;
          end else if (!fpu_busy_i) begin
            // Divider is free, so it launches on this edge.
            seen_busy_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= ST_DIV_WAIT;
          end
        end
        ST_DIV_WAIT: begin
          if (seen_busy_q && !fpu_busy_i) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fpu_res_i;
            resp_err_q   <= 1'b0;
            resp_id_q    <= id_q;
            op_q         <= 4'b0000;
            state_q      <= ST_IDLE;
          end else if (wdog_q == CNT_W'(DIV_MAX_CYCLES - 1)) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_id_q    <= id_q;
            op_q         <= 4'b0000;
            state_q      <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
            if (fpu_busy_i) seen_busy_q <= 1'b1;
          end
        end
        default: begin
          op_q    <= 4'b0000;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed testbench for fpu_req_arbiter with two requesters, a small
// behavioural FPU (add, signed min, scripted divide result) and a
// shortened divide watchdog.
module tb_fpu_req_arbiter;
  import fpu_ctrl_pkg::*;

  localparam int NREQ  = 2;
  localparam int TAG_W = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   reqValid = '0;
  logic [NREQ-1:0]   reqReady;
  logic [4*NREQ-1:0] reqOp = '0;
  logic [64*NREQ-1:0] reqA = '0;
  logic [64*NREQ-1:0] reqB = '0;
  logic              respValid;
  logic              respReady = 1'b0;
  logic [63:0]       respData;
  logic [TAG_W-1:0]  respId;
  logic              respErr;
  logic [3:0]        fpuOp;
  logic [63:0]       fpuA, fpuB;
  logic              fpuBusy = 1'b0;
  logic [63:0]       fpuRes;
  logic [63:0]       divResult = 64'h0;

  int checks = 0;
  int errors = 0;

  fpu_req_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DIV_MAX_CYCLES(16)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_op_i     (reqOp),
    .req_a_i      (reqA),
    .req_b_i      (reqB),
    .resp_valid_o (respValid),
    .resp_ready_i (respReady),
    .resp_data_o  (respData),
    .resp_id_o    (respId),
    .resp_err_o   (respErr),
    .fpu_op_o     (fpuOp),
    .fpu_a_o      (fpuA),
    .fpu_b_o      (fpuB),
    .fpu_busy_i   (fpuBusy),
    .fpu_res_i    (fpuRes)
  );

  always #5 clk = ~clk;

  // Behavioural FPU: divide result is scripted by the test, unknown ops
  // return a recognisable junk value.
  always_comb begin
    fpuRes = 64'h0BAD;
    case (fpuOp)
      FOP_ADD: fpuRes = fpuA + fpuB;
      FOP_MIN: fpuRes = ($signed(fpuA) < $signed(fpuB)) ? fpuA : fpuB;
      FOP_DIV: fpuRes = divResult;
      default: fpuRes = 64'h0BAD;
    endcase
  end

  task automatic applyStimulus(input int idx, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    reqOp[4*idx +: 4]  = op;
    reqA[64*idx +: 64] = a;
    reqB[64*idx +: 64] = b;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    reqValid  = '0;
    respReady = 1'b0;
    fpuBusy   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    applyStimulus(0, FOP_ADD, 64'h8000, 64'h10000);
    applyStimulus(1, FOP_MIN, 64'd5, 64'd7);
    reqValid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pre resp_valid got %b want 1", respValid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({respValid, respErr, respId, respData} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_resp got v=%b e=%b id=%0d d=%h want all 0",
               respValid, respErr, respId, respData);
    end
    checks++;
    if ({fpuOp, fpuA, fpuB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_fpu got op=%b a=%h b=%h want all 0", fpuOp, fpuA, fpuB);
    end
    checks++;
    if (reqReady !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b want 00", reqReady);
    end
    @(negedge clk);
    checks++;
    if (reqReady !== 2'b00 || respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got ready=%b v=%b want 00/0", reqReady, respValid);
    end
    reqValid = '0;
    reset    = 1'b0;
  endtask

  task automatic test_add();
    doReset();
    applyStimulus(0, FOP_ADD, 64'h8000, 64'h10000);
    reqValid = 2'b01;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin
      errors++;
      $display("[TB] FAIL add_grant got %b want 01", reqReady);
    end
    @(negedge clk);
    reqValid = '0;
    checks++;
    if (fpuA !== 64'h8000 || fpuB !== 64'h10000 || respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_exec got a=%h b=%h v=%b want 8000/10000/0", fpuA, fpuB, respValid);
    end
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respData !== 64'h18000 || respId !== 1'b0 || respErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_resp got v=%b d=%h id=%0d e=%b want 1/18000/0/0",
               respValid, respData, respId, respErr);
    end
    respReady = 1'b1;
    @(negedge clk);
    checks++;
    if (respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain got v=%b want 0", respValid);
    end
    respReady = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] expGrant;
    logic [63:0]     expData;
    doReset();
    applyStimulus(0, FOP_MIN, 64'd5, 64'd7);
    applyStimulus(1, FOP_MIN, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2);
    reqValid  = 2'b11;
    respReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
      expData  = (k % 2 == 0) ? 64'd5 : 64'hFFFF_FFFF_FFFF_FFFD;
      #1;
      checks++;
      if (reqReady !== expGrant) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d got %b want %b", k, reqReady, expGrant);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (respValid !== 1'b1 || respId !== TAG_W'(k % 2) || respData !== expData) begin
        errors++;
        $display("[TB] FAIL rr_resp%0d got v=%b id=%0d d=%h want 1/%0d/%h",
                 k, respValid, respId, respData, k % 2, expData);
      end
    end
    reqValid = '0;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic test_div_backpressure();
    logic bad;
    doReset();
    divResult = 64'hDEAD;
    applyStimulus(1, FOP_DIV, 64'h30000, 64'h10000);
    reqValid = 2'b10;
    #1;
    checks++;
    if (reqReady !== 2'b10) begin
      errors++;
      $display("[TB] FAIL div_grant got %b want 10", reqReady);
    end
    @(negedge clk);
    reqValid = '0;
    checks++;
    if (fpuOp !== FOP_DIV) begin
      errors++;
      $display("[TB] FAIL div_op got %b want 0011", fpuOp);
    end
    @(negedge clk);
    fpuBusy = 1'b1;
    applyStimulus(0, FOP_ADD, 64'd1, 64'd2);
    reqValid = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (reqReady !== 2'b00 || respValid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL div_busy_quiet got early grant or response want none");
    end
    fpuBusy   = 1'b0;
    divResult = 64'h18000;
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respData !== 64'h18000 || respId !== 1'b1 || respErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_resp got v=%b d=%h id=%0d e=%b want 1/18000/1/0",
               respValid, respData, respId, respErr);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (respValid !== 1'b1 || respData !== 64'h18000 || reqReady !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL div_hold got v=%b d=%h ready=%b want 1/18000/00",
               respValid, respData, reqReady);
    end
    respReady = 1'b1;
    #1;
    checks++;
    if (reqReady !== 2'b01) begin
      errors++;
      $display("[TB] FAIL div_b2b_grant got %b want 01", reqReady);
    end
    @(negedge clk);
    respReady = 1'b0;
    reqValid  = '0;
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respData !== 64'd3 || respId !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_next got v=%b d=%h id=%0d want 1/3/0", respValid, respData, respId);
    end
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic test_illegal();
    doReset();
    applyStimulus(0, 4'b0111, 64'h1234, 64'h5678);
    reqValid = 2'b01;
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respErr !== 1'b1 || respData !== 64'h0 || respId !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_resp got v=%b e=%b d=%h id=%0d want 1/1/0/0",
               respValid, respErr, respData, respId);
    end
    applyStimulus(1, FOP_ADD, 64'h100, 64'h200);
    reqValid  = 2'b10;
    respReady = 1'b1;
    #1;
    checks++;
    if (reqReady !== 2'b10) begin
      errors++;
      $display("[TB] FAIL illegal_next_grant got %b want 10", reqReady);
    end
    @(negedge clk);
    reqValid  = '0;
    respReady = 1'b0;
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respErr !== 1'b0 || respData !== 64'h300 || respId !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_next_resp got v=%b e=%b d=%h id=%0d want 1/0/300/1",
               respValid, respErr, respData, respId);
    end
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic test_watchdog();
    doReset();
    divResult = 64'hBEEF;
    applyStimulus(0, FOP_DIV, 64'h30000, 64'h10000);
    reqValid = 2'b01;
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    fpuBusy = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wdog_early got v=%b want 0", respValid);
    end
    @(negedge clk);
    checks++;
    if (respValid !== 1'b1 || respErr !== 1'b1 || respData !== 64'h0 || fpuOp !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL wdog_resp got v=%b e=%b d=%h op=%b want 1/1/0/0000",
               respValid, respErr, respData, fpuOp);
    end
    fpuBusy   = 1'b0;
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  // Scenarios run in sequence; each starts from its own reset.
  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_div_backpressure();
    test_illegal();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
